// File: rtl/sprite_blit_engine.sv
// Sprite blitter: scans a SPR_W x SPR_H sprite from a synchronous ROM and
// streams registered (x,y,colour,plot) to the VGA adapter, with origin
// offset, horizontal mirror, transparency skip, screen clipping and erase.
module sprite_blit_engine #(
  parameter int SPR_W     = 14,
  parameter int SPR_H     = 12,
  parameter int ADDR_W    = 8,
  parameter int ADDR_BASE = 0,
  parameter int COLOR_W   = 3,
  parameter int TRANSP    = 0,
  parameter int SCR_W     = 160,
  parameter int SCR_H     = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         origin_x,
  input  logic [6:0]         origin_y,
  input  logic               mirror,
  input  logic               erase,
  input  logic [COLOR_W-1:0] erase_color,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_plot,
  output logic               busy,
  output logic               done
);
  localparam int CW     = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW     = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH1, FLUSH2} state_t;
  state_t state, state_nx;

  // Scan position of the pixel currently on rom_addr, plus row*SPR_W
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [ADDR_W-1:0]  rbase;

  // Parameters of the blit in flight, captured on the accepted start
  logic [7:0]         ox_q;
  logic [6:0]         oy_q;
  logic               mir_q, er_q;
  logic [COLOR_W-1:0] ec_q;

  // Two-stage pipeline: [0] = address issued, [1] = ROM data valid
  logic [STAGES:0]    vld_pipe;
  logic [8:0]         a_x, b_x;   // one extra bit so overflow is clipped
  logic [7:0]         a_y, b_y;
  logic               a_last, b_last;

  // Issue-side combinational signals
  logic               accept, iss, iss_mir, last_col, last_px;
  logic [CW-1:0]      iss_col, iss_c;
  logic [RW-1:0]      iss_row;
  logic [ADDR_W-1:0]  iss_base, iss_addr;
  logic [7:0]         ox_s;
  logic [6:0]         oy_s;

  assign last_col = (col == CW'(SPR_W - 1));
  assign last_px  = last_col && (row == RW'(SPR_H - 1));
  assign busy     = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and the next pixel to issue to the ROM
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    iss      = 1'b0;
    iss_col  = '0;
    iss_row  = '0;
    iss_base = '0;
    iss_mir  = mir_q;
    ox_s     = ox_q;
    oy_s     = oy_q;
    case (state)
      IDLE: if (start) begin
        accept   = 1'b1;
        iss      = 1'b1;
        iss_mir  = mirror;
        ox_s     = origin_x;
        oy_s     = origin_y;
        state_nx = FETCH;
      end
      FETCH: if (last_px) begin
        state_nx = FLUSH1;
      end else begin
        iss = 1'b1;
        if (last_col) begin
          iss_row  = row + RW'(1);
          iss_base = rbase + ADDR_W'(SPR_W);
        end else begin
          iss_col  = col + CW'(1);
          iss_row  = row;
          iss_base = rbase;
        end
      end
      FLUSH1:  state_nx = FLUSH2;
      default: state_nx = IDLE;
    endcase
  end

  // Mirroring only changes which ROM column is read; screen x stays unmirrored
  assign iss_c    = iss_mir ? (CW'(SPR_W - 1) - iss_col) : iss_col;
  assign iss_addr = ADDR_W'(ADDR_BASE) + iss_base + ADDR_W'(iss_c);

  // Latches, scan counters, address/coordinate pipeline and VGA outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      rbase     <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      mir_q     <= 1'b0;
      er_q      <= 1'b0;
      ec_q      <= '0;
      rom_addr  <= ADDR_W'(ADDR_BASE);
      vld_pipe  <= '0;
      a_x       <= '0;
      a_y       <= '0;
      a_last    <= 1'b0;
      b_x       <= '0;
      b_y       <= '0;
      b_last    <= 1'b0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
      vga_plot  <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (accept) begin
        ox_q  <= origin_x;
        oy_q  <= origin_y;
        mir_q <= mirror;
        er_q  <= erase;
        ec_q  <= erase_color;
      end
      if (iss) begin
        col      <= iss_col;
        row      <= iss_row;
        rbase    <= iss_base;
        rom_addr <= iss_addr;
        a_x      <= {1'b0, ox_s} + 9'(iss_col);
        a_y      <= {1'b0, oy_s} + 8'(iss_row);
        a_last   <= (iss_col == CW'(SPR_W - 1)) && (iss_row == RW'(SPR_H - 1));
      end
      vld_pipe <= {vld_pipe[STAGES-1:0], iss};
      b_x      <= a_x;
      b_y      <= a_y;
      b_last   <= a_last;
      vga_plot <= vld_pipe[STAGES] && (rom_data != COLOR_W'(TRANSP)) &&
                  (b_x <= 9'(SCR_W - 1)) && (b_y <= 8'(SCR_H - 1));
      done     <= vld_pipe[STAGES] && b_last;
      if (vld_pipe[STAGES]) begin
        vga_x     <= b_x[7:0];
        vga_y     <= b_y[6:0];
        vga_color <= er_q ? ec_q : rom_data;
      end
    end
  end
endmodule

// File: doc/sprite_blit_engine.md
Name: sprite_blit_engine

Overview:
Parametrised sprite drawing engine that replaces the fixed-size per-sprite drawers (cat, invader, dead invader, background). On a start pulse it scans a W×H sprite stored in an external synchronous ROM and emits screen-space (x,y,colour,plot) to the VGA adapter. Beyond the fixed drawers it adds:
- latched origin offset
- horizontal mirroring
- transparent-colour skipping
- screen-edge clipping
- an erase mode for the draw/erase refresh method
- a single-cycle done pulse
It sits between the game FSM and the VGA adapter; one instance serves each sprite type.

Parameters:
SPR_W, 14, sprite width in pixels (1..256)
SPR_H, 12, sprite height in pixels (1..128)
ADDR_W, 8, ROM address width; must satisfy ADDR_BASE+SPR_W*SPR_H <= 2^ADDR_W
ADDR_BASE, 0, ROM address of sprite pixel (0,0)
COLOR_W, 3, pixel colour width
TRANSP, 0, colour value treated as transparent
SCR_W, 160, screen width; SCR_XW=8 bits
SCR_H, 120, screen height; SCR_YW=7 bits

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  request a blit; sampled only when busy=0
origin_x  in  8  screen x of sprite left edge; latched on accepted start
origin_y  in  7  screen y of sprite top edge; latched on accepted start
mirror  in  1  1 = horizontally flipped; latched on accepted start
erase  in  1  1 = plot erase_color instead of sprite colour; latched on accepted start
erase_color  in  COLOR_W  colour used in erase mode; latched on accepted start
rom_addr  out  ADDR_W  sprite ROM address, registered
rom_data  in  COLOR_W  ROM output; 1-cycle read latency
vga_x  out  8  pixel x, registered
vga_y  out  7  pixel y, registered
vga_color  out  COLOR_W  pixel colour, registered
vga_plot  out  1  write strobe for the current vga_x/y/color
busy  out  1  high from the cycle after accepted start until return to IDLE
done  out  1  one-cycle pulse coincident with the last pixel slot

Behaviour:
- Reset values: all outputs 0. rom_addr=ADDR_BASE. State IDLE. Latched origin/mode registers cleared.
- Reset asserted mid-blit aborts immediately:
  - next cycle is IDLE with all outputs at reset values
  - no done pulse is produced
- States: IDLE -> FETCH -> FLUSH1 -> FLUSH2 -> IDLE. Let N = SPR_W*SPR_H and edge E0 be the edge that accepts start.
  - IDLE: start=1 at edge E0 latches inputs, loads col=0/row=0, enters FETCH.
  - FETCH: lasts exactly N cycles (after E0 .. after E(N-1)). rom_addr for pixel k is presented after edge Ek. After the pixel at col=SPR_W-1,row=SPR_H-1, enters FLUSH1.
  - FLUSH1 and FLUSH2: one cycle each, draining the two-stage pipeline. FLUSH2 returns to IDLE.
- Scan order: row-major, col 0..SPR_W-1, then row+1. The col counter wraps to 0 at SPR_W-1 and row increments.
- Address:
  - rom_addr = ADDR_BASE + row*SPR_W + c, where c = mirror ? SPR_W-1-col : col.
  - Computed with a row-base accumulator (add SPR_W per row); no multiplier.
- Pipeline:
  - Pixel k's rom_data is valid after E(k+1).
  - Pixel k's vga_* outputs are registered at E(k+2).
  - Screen coords: vga_x = origin_x+col, vga_y = origin_y+row. These are always unmirrored positions, computed at full width+1 to detect overflow.
- Plot rule for a pixel slot: vga_plot=1 iff all of the following hold:
  - rom_data != TRANSP
  - origin_x+col <= SCR_W-1
  - origin_y+row <= SCR_H-1
- Plot colour: vga_color = erase ? erase_color : rom_data.
- Outside a pixel slot: vga_plot=0. vga_x/y/color hold their last values.
- Clipped pixels still consume their cycle. Latency is independent of position and content.
- done=1 for exactly one cycle, after E(N+1), together with the last pixel slot.
- busy=1 after E0 through the FLUSH2 cycle; it drops after E(N+2). The earliest next start is accepted at E(N+3).
- start while busy=1 is ignored; latched values are unaffected. start held high in IDLE triggers one blit per return to IDLE.
- Input changes to origin/mirror/erase during busy have no effect.

Test Plan:
1. Default params, opaque ROM (all 3'b101), origin (10,20), start one cycle -> first plot after E2 at (10,20); last plot (23,31) after E169; 168 plots total; done high only after E169; busy low after E170.
2. ROM (0,0)=TRANSP, rest 3'b010 -> slot for (10,20) has vga_plot=0; 167 plots; done timing unchanged.
3. mirror=1, ROM value = address -> first slot rom_addr=ADDR_BASE+13, plotted at x=origin_x, colour 13; row1 first address 27.
4. Origin (150,115), opaque sprite -> exactly 50 plots (cols 0..9, rows 0..4); no x>159 or y>119 plotted; done still after E169.
5. erase=1, erase_color=3'b000, sprite with 40 transparent pixels -> 128 plots, all colour 0.
6. start pulsed at cycle 50 of a blit -> ignored, single done. Then reset at cycle 80 of a new blit -> next cycle busy=0, vga_plot=0, no done. Start after reset -> full correct blit.
